// File: rtl/branch_update_queue_if.sv
// Commit/update handshake bundle for branch_update_queue.
// master = ROB/predictor side, slave = the queue.
interface branch_update_queue_if #(
  parameter int GHR_BITS = 10
);
  logic                cmt_valid;
  logic                cmt_ready;
  logic [31:0]         cmt_pc;
  logic                cmt_branch;
  logic                cmt_jal;
  logic                cmt_taken;
  logic [31:0]         cmt_target;
  logic                cmt_pred_taken;
  logic [GHR_BITS-1:0] cmt_gshare_index;
  logic                upd_valid;
  logic                upd_ready;
  logic [31:0]         upd_pc;
  logic [31:0]         upd_target;
  logic                upd_taken;
  logic                upd_branch;
  logic                upd_jal;
  logic [GHR_BITS-1:0] upd_gshare_index;
  logic                upd_mispred;

  modport master (
    output cmt_valid, cmt_pc, cmt_branch, cmt_jal,
    output cmt_taken, cmt_target, cmt_pred_taken,
    output cmt_gshare_index, upd_ready,
    input  cmt_ready, upd_valid, upd_pc, upd_target,
    input  upd_taken, upd_branch, upd_jal,
    input  upd_gshare_index, upd_mispred
  );

  modport slave (
    input  cmt_valid, cmt_pc, cmt_branch, cmt_jal,
    input  cmt_taken, cmt_target, cmt_pred_taken,
    input  cmt_gshare_index, upd_ready,
    output cmt_ready, upd_valid, upd_pc, upd_target,
    output upd_taken, upd_branch, upd_jal,
    output upd_gshare_index, upd_mispred
  );
endinterface

// File: rtl/branch_update_queue.sv
// Commit-side FIFO feeding predictor updates; keeps retired GHR.
// Optional BP_STATS_EN adds branch / mispredict counters.
module branch_update_queue #(
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = 3,
  parameter int GHR_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  branch_update_queue_if.slave bus,
  output logic [GHR_BITS-1:0] arch_ghr
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
`endif
);

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         target;
    logic                taken;
    logic                branch;
    logic                jal;
    logic                mispred;
    logic [GHR_BITS-1:0] idx;
  } entry_t;

  localparam logic [PTR_BITS:0] FULL_CNT =
    (PTR_BITS+1)'(DEPTH);

  entry_t              mem [DEPTH];
  entry_t              head;
  entry_t              wr_entry;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS:0]   count;
  logic                full;
  logic                enq;
  logic                deq;

  assign full          = (count == FULL_CNT);
  assign bus.cmt_ready = !full;
  assign bus.upd_valid = (count != '0);

  assign enq = bus.cmt_valid & !full &
               (bus.cmt_branch | bus.cmt_jal);
  assign deq = bus.upd_valid & bus.upd_ready;

  // JAL wins when both flags are set
  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = bus.cmt_pc;
    wr_entry.target  = bus.cmt_target;
    wr_entry.jal     = bus.cmt_jal;
    wr_entry.branch  = bus.cmt_branch & ~bus.cmt_jal;
    wr_entry.taken   = bus.cmt_jal | bus.cmt_taken;
    wr_entry.mispred = wr_entry.taken ^ bus.cmt_pred_taken;
    wr_entry.idx     = bus.cmt_gshare_index;
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= wr_entry;
  end

  assign head                 = mem[rd_ptr];
  assign bus.upd_pc           = head.pc;
  assign bus.upd_target       = head.target;
  assign bus.upd_taken        = head.taken;
  assign bus.upd_branch       = head.branch;
  assign bus.upd_jal          = head.jal;
  assign bus.upd_gshare_index = head.idx;
  assign bus.upd_mispred      = head.mispred;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      arch_ghr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (deq && head.branch)
        arch_ghr <= {arch_ghr[GHR_BITS-2:0], head.taken};
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (deq) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + 1'b1;
      if (head.mispred && stat_mispred != '1)
        stat_mispred <= stat_mispred + 1'b1;
    end
  end
`endif

endmodule
